// File: rtl/fxp_accum.sv
// fxp_accum: saturating Q2.14 accumulator fed by the mult product stream.
// Sums signed terms in a guard-bit-extended register. Ends a vector on an
// accepted in_last or on the MAX_TERMS-th term, then presents one saturated
// result until the consumer takes it.
//
// Ports:
//   clk, rst_n        clock (rising edge), async active-low reset
//   in_data           signed product term (Q2.14)
//   in_ovf, in_unf    upstream multiplier flags for the term
//   in_valid, in_last term handshake and end-of-vector marker
//   in_ready          accepting terms (ACC state)
//   out_data          saturated result (Q2.14)
//   out_count         number of terms summed into out_data
//   overflow_flag     result clipped high (or upstream overflow, see macro)
//   underflow_flag    result clipped low (or upstream underflow, see macro)
//   out_valid         result present (OUT state)
//   out_ready         consumer takes the result
//
// Optional feature: define FXP_ACC_UPSTREAM_FLAGS_EN to OR sticky upstream
// in_ovf/in_unf of accepted terms into the output flags.

module fxp_accum #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned FRAC_WIDTH = 14,
    parameter int unsigned GUARD_BITS = 4,
    parameter int unsigned MAX_TERMS  = 16,
    localparam int unsigned CNT_WIDTH = $clog2(MAX_TERMS + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_ovf,
    input  logic                  in_unf,
    input  logic                  in_valid,
    input  logic                  in_last,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [CNT_WIDTH-1:0]  out_count,
    output logic                  overflow_flag,
    output logic                  underflow_flag,
    output logic                  out_valid,
    input  logic                  out_ready
);

    localparam int unsigned ACC_WIDTH = DATA_WIDTH + GUARD_BITS;
    localparam logic signed [ACC_WIDTH-1:0] SAT_MAX = ACC_WIDTH'((2 ** (DATA_WIDTH - 1)) - 1);
    localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = ~SAT_MAX;

    // Elaboration guards: the guard bits must cover a full vector of terms.
    if (MAX_TERMS > (2 ** GUARD_BITS)) begin : g_bad_terms
        $error("fxp_accum: MAX_TERMS exceeds 2**GUARD_BITS");
    end
    if (FRAC_WIDTH >= DATA_WIDTH) begin : g_bad_frac
        $error("fxp_accum: FRAC_WIDTH must be below DATA_WIDTH");
    end

    typedef enum logic {
        ST_ACC = 1'b0,
        ST_OUT = 1'b1
    } state_t;

    state_t                      state_q, state_d;
    logic signed [ACC_WIDTH-1:0] acc_q, acc_d;
    logic [CNT_WIDTH-1:0]        cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]       out_data_q, out_data_d;
    logic [CNT_WIDTH-1:0]        out_count_q, out_count_d;
    logic                        ovf_q, ovf_d;
    logic                        unf_q, unf_d;
    logic                        out_valid_q, out_valid_d;
    logic                        in_ready_q, in_ready_d;

    logic signed [ACC_WIDTH-1:0] in_ext;
    logic signed [ACC_WIDTH-1:0] sum;
    logic [CNT_WIDTH-1:0]        cnt_inc;
    logic                        accept;
    logic                        end_vec;
    logic                        stk_ovf_nxt;
    logic                        stk_unf_nxt;

`ifdef FXP_ACC_UPSTREAM_FLAGS_EN
    logic stk_ovf_q, stk_ovf_d;
    logic stk_unf_q, stk_unf_d;
`else
    logic unused_upstream_flags;
    assign unused_upstream_flags = in_ovf ^ in_unf;
`endif

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_ACC;
            acc_q       <= '0;
            cnt_q       <= '0;
            out_data_q  <= '0;
            out_count_q <= '0;
            ovf_q       <= 1'b0;
            unf_q       <= 1'b0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
`ifdef FXP_ACC_UPSTREAM_FLAGS_EN
            stk_ovf_q   <= 1'b0;
            stk_unf_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            out_data_q  <= out_data_d;
            out_count_q <= out_count_d;
            ovf_q       <= ovf_d;
            unf_q       <= unf_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
`ifdef FXP_ACC_UPSTREAM_FLAGS_EN
            stk_ovf_q   <= stk_ovf_d;
            stk_unf_q   <= stk_unf_d;
`endif
        end
    end

    // Next-state, accumulate and result saturation.
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        out_data_d  = out_data_q;
        out_count_d = out_count_q;
        ovf_d       = ovf_q;
        unf_d       = unf_q;
        out_valid_d = out_valid_q;
        in_ready_d  = in_ready_q;
        stk_ovf_nxt = 1'b0;
        stk_unf_nxt = 1'b0;
`ifdef FXP_ACC_UPSTREAM_FLAGS_EN
        stk_ovf_d   = stk_ovf_q;
        stk_unf_d   = stk_unf_q;
`endif

        in_ext  = {{GUARD_BITS{in_data[DATA_WIDTH-1]}}, in_data};
        sum     = acc_q + in_ext;
        cnt_inc = CNT_WIDTH'(cnt_q + CNT_WIDTH'(1));
        accept  = (state_q == ST_ACC) && in_valid;
        end_vec = accept && (in_last || (cnt_inc == CNT_WIDTH'(MAX_TERMS)));

`ifdef FXP_ACC_UPSTREAM_FLAGS_EN
        stk_ovf_nxt = stk_ovf_q | (accept & in_ovf);
        stk_unf_nxt = stk_unf_q | (accept & in_unf);
`endif

        case (state_q)
            ST_ACC: begin
                if (accept) begin
                    acc_d = sum;
                    cnt_d = cnt_inc;
`ifdef FXP_ACC_UPSTREAM_FLAGS_EN
                    stk_ovf_d = stk_ovf_nxt;
                    stk_unf_d = stk_unf_nxt;
`endif
                end
                if (end_vec) begin
                    state_d     = ST_OUT;
                    out_valid_d = 1'b1;
                    in_ready_d  = 1'b0;
                    out_count_d = cnt_inc;
                    ovf_d       = stk_ovf_nxt;
                    unf_d       = stk_unf_nxt;
                    if (sum > SAT_MAX) begin
                        out_data_d = {1'b0, {(DATA_WIDTH - 1){1'b1}}};
                        ovf_d      = 1'b1;
                    end else if (sum < SAT_MIN) begin
                        out_data_d = {1'b1, {(DATA_WIDTH - 1){1'b0}}};
                        unf_d      = 1'b1;
                    end else begin
                        out_data_d = sum[DATA_WIDTH-1:0];
                    end
                end
            end
            ST_OUT: begin
                // Handshake edge clears the vector state; no term taken here.
                if (out_ready) begin
                    state_d     = ST_ACC;
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    acc_d       = '0;
                    cnt_d       = '0;
`ifdef FXP_ACC_UPSTREAM_FLAGS_EN
                    stk_ovf_d   = 1'b0;
                    stk_unf_d   = 1'b0;
`endif
                end
            end
            default: begin
                state_d = ST_ACC;
            end
        endcase
    end

    assign in_ready       = in_ready_q;
    assign out_valid      = out_valid_q;
    assign out_data       = out_data_q;
    assign out_count      = out_count_q;
    assign overflow_flag  = ovf_q;
    assign underflow_flag = unf_q;

endmodule

// File: tb/tb_fxp_accum.sv
// Directed testbench for fxp_accum. Inputs are driven and outputs sampled on
// the falling clock edge; DUT registers on the rising edge.
`timescale 1ns/1ps

module tb_fxp_accum;

    logic        clk;
    logic        rst_n;
    logic [15:0] in_data;
    logic        in_ovf;
    logic        in_unf;
    logic        in_valid;
    logic        in_last;
    logic        in_ready;
    logic [15:0] out_data;
    logic [4:0]  out_count;
    logic        overflow_flag;
    logic        underflow_flag;
    logic        out_valid;
    logic        out_ready;

    int checks = 0;
    int errors = 0;

    fxp_accum dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_data        (in_data),
        .in_ovf         (in_ovf),
        .in_unf         (in_unf),
        .in_valid       (in_valid),
        .in_last        (in_last),
        .in_ready       (in_ready),
        .out_data       (out_data),
        .out_count      (out_count),
        .overflow_flag  (overflow_flag),
        .underflow_flag (underflow_flag),
        .out_valid      (out_valid),
        .out_ready      (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Present one term for exactly one rising edge (DUT must be in ACC).
    task automatic send(input logic [15:0] d, input logic last, input logic ovf, input logic unf);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        in_ovf   = ovf;
        in_unf   = unf;
    endtask

    task automatic idle_in();
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_ovf   = 1'b0;
        in_unf   = 1'b0;
        in_data  = 16'h0000;
    endtask

    task automatic check_result(input string tag, input logic [15:0] d, input logic [4:0] c,
                                input logic ov, input logic un);
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_data"}, 32'(out_data), 32'(d));
        check({tag, "_count"}, 32'(out_count), 32'(c));
        check({tag, "_ovf"}, 32'(overflow_flag), 32'(ov));
        check({tag, "_unf"}, 32'(underflow_flag), 32'(un));
        check({tag, "_inrdy"}, 32'(in_ready), 32'd0);
    endtask

    logic exp_up_ovf;

    initial begin
`ifdef FXP_ACC_UPSTREAM_FLAGS_EN
        exp_up_ovf = 1'b1;
`else
        exp_up_ovf = 1'b0;
`endif
        rst_n     = 1'b0;
        in_data   = 16'h0000;
        in_ovf    = 1'b0;
        in_unf    = 1'b0;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_inrdy", 32'(in_ready), 32'd1);
        check("rst_outvalid", 32'(out_valid), 32'd0);
        check("rst_data", 32'(out_data), 32'd0);
        check("rst_count", 32'(out_count), 32'd0);
        check("rst_flags", 32'({overflow_flag, underflow_flag}), 32'd0);
        rst_n = 1'b1;

        // Basic sum with the consumer always ready: out_valid lasts one cycle.
        out_ready = 1'b1;
        send(16'h1000, 1'b0, 1'b0, 1'b0);
        send(16'h1000, 1'b0, 1'b0, 1'b0);
        send(16'h2000, 1'b1, 1'b0, 1'b0);
        idle_in();
        check_result("basic", 16'h4000, 5'd3, 1'b0, 1'b0);
        @(negedge clk);
        check("basic_vld_drop", 32'(out_valid), 32'd0);
        check("basic_inrdy_back", 32'(in_ready), 32'd1);

        // Positive clip: 1.0 + 1.0 exceeds Q2.14 range.
        out_ready = 1'b0;
        send(16'h4000, 1'b0, 1'b0, 1'b0);
        send(16'h4000, 1'b1, 1'b0, 1'b0);
        idle_in();
        check_result("posclip", 16'h7FFF, 5'd2, 1'b1, 1'b0);
        out_ready = 1'b1;
        @(negedge clk);
        check("posclip_done", 32'(out_valid), 32'd0);

        // Negative clip: -2.0 + -1.0.
        out_ready = 1'b0;
        send(16'h8000, 1'b0, 1'b0, 1'b0);
        send(16'hC000, 1'b1, 1'b0, 1'b0);
        idle_in();
        check_result("negclip", 16'h8000, 5'd2, 1'b0, 1'b1);
        out_ready = 1'b1;
        @(negedge clk);
        check("negclip_done", 32'(out_valid), 32'd0);

        // Count limit: 16 terms of 0x0100 with in_last low end the vector.
        out_ready = 1'b0;
        for (int i = 0; i < 16; i++) send(16'h0100, 1'b0, 1'b0, 1'b0);
        // Keep a term presented: it must be held off while in OUT.
        @(negedge clk);
        in_data = 16'h7000;
        in_last = 1'b1;
        check_result("limit", 16'h1000, 5'd16, 1'b0, 1'b0);
        @(negedge clk);
        check("limit_hold_vld", 32'(out_valid), 32'd1);
        check("limit_hold_inrdy", 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        @(negedge clk);
        // Handshake edge took no term; accumulator restarts from zero.
        check("limit_post_vld", 32'(out_valid), 32'd0);
        check("limit_post_inrdy", 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        check_result("limit_next", 16'h7000, 5'd1, 1'b0, 1'b0);
        @(negedge clk);
        check("limit_next_done", 32'(out_valid), 32'd0);

        // Back-pressure then reset while in OUT: result is discarded.
        out_ready = 1'b0;
        send(16'h0300, 1'b1, 1'b0, 1'b0);
        idle_in();
        for (int i = 0; i < 5; i++) begin
            check("bp_data", 32'(out_data), 32'h0300);
            check("bp_inrdy", 32'(in_ready), 32'd0);
            @(negedge clk);
        end
        rst_n = 1'b0;
        #1;
        check("mrst_valid", 32'(out_valid), 32'd0);
        check("mrst_data", 32'(out_data), 32'd0);
        check("mrst_count", 32'(out_count), 32'd0);
        check("mrst_flags", 32'({overflow_flag, underflow_flag}), 32'd0);
        check("mrst_inrdy", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("mrst_no_emit", 32'(out_valid), 32'd0);

        // Reset mid-vector discards the partial sum.
        send(16'h2000, 1'b0, 1'b0, 1'b0);
        idle_in();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b0;
        send(16'h0010, 1'b1, 1'b0, 1'b0);
        idle_in();
        check_result("partial_rst", 16'h0010, 5'd1, 1'b0, 1'b0);
        out_ready = 1'b1;
        @(negedge clk);

        // Upstream flag on an accepted term; flag on an invalid cycle ignored.
        out_ready = 1'b0;
        send(16'h0100, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        in_unf   = 1'b1;
        in_ovf   = 1'b0;
        in_last  = 1'b1;
        send(16'h0100, 1'b1, 1'b0, 1'b0);
        idle_in();
        check_result("upflags", 16'h0200, 5'd2, exp_up_ovf, 1'b0);
        out_ready = 1'b1;
        @(negedge clk);

        // Sticky bits cleared: a clean vector after the flagged one.
        out_ready = 1'b0;
        send(16'hFF00, 1'b1, 1'b0, 1'b0);
        idle_in();
        check_result("sticky_clr", 16'hFF00, 5'd1, 1'b0, 1'b0);
        out_ready = 1'b1;
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
